// File: rtl/rn_recover_ctrl_pkg.sv
// rtl/rn_recover_ctrl_pkg.sv - shared types and widths for rename-state recovery
// Purpose: default register-file index widths and the recovery FSM state type.
// Ports: none (package).
package rn_recover_ctrl_pkg;

  localparam int NCPU_LRF_AW = 5;
  localparam int NCPU_PRF_AW = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_WALK  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_SCAN  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/rn_recover_ctrl_if.sv
// rtl/rn_recover_ctrl_if.sv - recovery controller bus bundle
// Purpose: groups the flush request, ARAT read port, speculative RAT write port,
//          free-list push/clear port, busytable clear and recovery status.
// Ports (master = recovery controller side):
//   in : flush, arat_rdata, fl_push_ready
//   out: arat_raddr, rat_rcv_we, rat_rcv_lrd, rat_rcv_prd, fl_clear, fl_push,
//        fl_push_prd, bt_clear, rcv_busy, rcv_done
interface rn_recover_ctrl_if
  import rn_recover_ctrl_pkg::*;
#(
  parameter int LRF_AW = NCPU_LRF_AW,
  parameter int PRF_AW = NCPU_PRF_AW
) ();

  logic              flush;
  logic [LRF_AW-1:0] arat_raddr;
  logic [PRF_AW-1:0] arat_rdata;
  logic              rat_rcv_we;
  logic [LRF_AW-1:0] rat_rcv_lrd;
  logic [PRF_AW-1:0] rat_rcv_prd;
  logic              fl_clear;
  logic              fl_push;
  logic [PRF_AW-1:0] fl_push_prd;
  logic              fl_push_ready;
  logic              bt_clear;
  logic              rcv_busy;
  logic              rcv_done;

  modport master (
    input  flush, arat_rdata, fl_push_ready,
    output arat_raddr, rat_rcv_we, rat_rcv_lrd, rat_rcv_prd,
           fl_clear, fl_push, fl_push_prd, bt_clear, rcv_busy, rcv_done
  );

  modport slave (
    output flush, arat_rdata, fl_push_ready,
    input  arat_raddr, rat_rcv_we, rat_rcv_lrd, rat_rcv_prd,
           fl_clear, fl_push, fl_push_prd, bt_clear, rcv_busy, rcv_done
  );

endinterface

// File: rtl/rn_recover_ctrl.sv
// rtl/rn_recover_ctrl.sv - rename-state recovery sequencer after a pipeline flush
// Purpose: clears free list and busytable, walks the ARAT copying every mapping
//          into the speculative RAT while marking those PRs in use, then scans
//          all PRs and pushes each unused one into the free list.
// Ports:
//   clk  in  clock
//   rst  in  asynchronous reset, active high
//   bus  master modport of rn_recover_ctrl_if (flush request, ARAT read,
//        RAT write, free-list push/clear, busytable clear, busy/done status)
module rn_recover_ctrl
  import rn_recover_ctrl_pkg::*;
#(
  parameter int LRF_AW = NCPU_LRF_AW,
  parameter int PRF_AW = NCPU_PRF_AW
) (
  input  logic                 clk,
  input  logic                 rst,
  rn_recover_ctrl_if.master    bus
);

  localparam int NLR = 1 << LRF_AW;
  localparam int NPR = 1 << PRF_AW;
  localparam logic [LRF_AW-1:0] LR_LAST = LRF_AW'(NLR - 1);
  localparam logic [PRF_AW-1:0] PR_LAST = PRF_AW'(NPR - 1);

  state_t            state;
  state_t            state_nxt;
  logic [LRF_AW-1:0] lr_cnt;
  logic [LRF_AW-1:0] wr_lrd;
  logic              wr_pend;
  logic [PRF_AW-1:0] pr_cnt;
  logic [NPR-1:0]    inuse;
  logic              cur_inuse;
  logic              scan_adv;

  assign cur_inuse = inuse[pr_cnt];
  // In-use PRs are skipped in one cycle; free ones wait for the free list.
  assign scan_adv  = (state == ST_SCAN) && (cur_inuse || bus.fl_push_ready);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a flush in any state restarts at CLR
  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = ST_CLR;
    end else begin
      case (state)
        ST_IDLE:  state_nxt = ST_IDLE;
        ST_CLR:   state_nxt = ST_WALK;
        ST_WALK:  if (lr_cnt == LR_LAST) state_nxt = ST_DRAIN;
        ST_DRAIN: state_nxt = ST_SCAN;
        ST_SCAN:  if (scan_adv && (pr_cnt == PR_LAST)) state_nxt = ST_DONE;
        ST_DONE:  state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Counters, delayed write tracking and the in-use bitmap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lr_cnt  <= '0;
      wr_lrd  <= '0;
      wr_pend <= 1'b0;
      pr_cnt  <= '0;
      inuse   <= '0;
    end else begin
      // ARAT read data lands one cycle after the address; a flush kills the
      // pending write so nothing from the aborted walk leaks past CLR.
      wr_pend <= (state == ST_WALK) && !bus.flush;
      if (state == ST_WALK) begin
        wr_lrd <= lr_cnt;
      end

      if (state == ST_CLR) begin
        lr_cnt <= '0;
      end else if ((state == ST_WALK) && (lr_cnt != LR_LAST)) begin
        lr_cnt <= lr_cnt + 1'b1;
      end

      // Scan starts at PR 1: PR 0 is the zero register and never freed.
      if (state == ST_DRAIN) begin
        pr_cnt <= PRF_AW'(1);
      end else if (scan_adv && (pr_cnt != PR_LAST)) begin
        pr_cnt <= pr_cnt + 1'b1;
      end

      if (state == ST_CLR) begin
        inuse <= NPR'(1);
      end else if (wr_pend) begin
        inuse[bus.arat_rdata] <= 1'b1;
      end
    end
  end

  // Output decode from registered state only
  always_comb begin
    bus.arat_raddr  = '0;
    bus.rat_rcv_we  = 1'b0;
    bus.rat_rcv_lrd = '0;
    bus.rat_rcv_prd = '0;
    bus.fl_clear    = 1'b0;
    bus.bt_clear    = 1'b0;
    bus.fl_push     = 1'b0;
    bus.fl_push_prd = '0;
    bus.rcv_busy    = (state != ST_IDLE);
    bus.rcv_done    = (state == ST_DONE);

    if (state == ST_WALK) begin
      bus.arat_raddr = lr_cnt;
    end
    if (wr_pend) begin
      bus.rat_rcv_we  = 1'b1;
      bus.rat_rcv_lrd = wr_lrd;
      bus.rat_rcv_prd = bus.arat_rdata;
    end
    if (state == ST_CLR) begin
      bus.fl_clear = 1'b1;
      bus.bt_clear = 1'b1;
    end
    if (state == ST_SCAN) begin
      bus.fl_push     = !cur_inuse;
      bus.fl_push_prd = pr_cnt;
    end
  end

endmodule
